// File: rtl/brick_sort_iter.sv
// brick_sort_iter: iterative odd-even transposition (brick) sorter, one phase per clock.
// Optional macro BRICK_SORT_EARLY_EXIT_EN ends early after two consecutive swap-free phases.
module brick_sort_iter #(
   parameter int LOG_INPUT_NUM = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int SIGNED        = 0,
   parameter int ASCENDING     = 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0] in_data,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0] out_data,
   output logic                                    busy,
   output logic [LOG_INPUT_NUM:0]                  phase_count
);

   localparam int N  = 2**LOG_INPUT_NUM;
   localparam int W  = DATA_WIDTH;
   localparam int CW = LOG_INPUT_NUM + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SORT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [1:0]     state_q, state_d;
   logic [N*W-1:0] data_q, data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N*W-1:0] nxt;
   logic           sort_end;
`ifdef BRICK_SORT_EARLY_EXIT_EN
   logic           swp;
   logic           prev_swp_q, prev_swp_d;
`endif

   function automatic logic out_of_order(
      input logic [W-1:0] a,
      input logic [W-1:0] b
   );
      logic a_gt_b;
      logic b_gt_a;
      if (SIGNED != 0) begin
         a_gt_b = $signed(a) > $signed(b);
         b_gt_a = $signed(b) > $signed(a);
      end else begin
         a_gt_b = a > b;
         b_gt_a = b > a;
      end
      return (ASCENDING != 0) ? a_gt_b : b_gt_a;
   endfunction

   // Phase parity picks the pair offset: even phases start at 0, odd at 1.
   always_comb begin
      nxt = data_q;
`ifdef BRICK_SORT_EARLY_EXIT_EN
      swp = 1'b0;
`endif
      for (int i = 0; i < N - 1; i++) begin
         if (1'(i) == cnt_q[0]) begin
            if (out_of_order(data_q[i*W +: W], data_q[(i+1)*W +: W])) begin
               nxt[i*W +: W]     = data_q[(i+1)*W +: W];
               nxt[(i+1)*W +: W] = data_q[i*W +: W];
`ifdef BRICK_SORT_EARLY_EXIT_EN
               swp = 1'b1;
`endif
            end
         end
      end
   end

`ifdef BRICK_SORT_EARLY_EXIT_EN
   assign sort_end = (cnt_q == LAST) ||
                     ((cnt_q != '0) && !swp && !prev_swp_q);
`else
   assign sort_end = (cnt_q == LAST);
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef BRICK_SORT_EARLY_EXIT_EN
      prev_swp_d = prev_swp_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               cnt_d   = '0;
               state_d = S_SORT;
`ifdef BRICK_SORT_EARLY_EXIT_EN
               prev_swp_d = 1'b1;
`endif
            end
         end
         S_SORT: begin
            data_d = nxt;
            cnt_d  = cnt_q + ONE;
`ifdef BRICK_SORT_EARLY_EXIT_EN
            prev_swp_d = swp;
`endif
            if (sort_end) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
`ifdef BRICK_SORT_EARLY_EXIT_EN
         prev_swp_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
`ifdef BRICK_SORT_EARLY_EXIT_EN
         prev_swp_q <= prev_swp_d;
`endif
      end
   end

   assign in_ready    = (state_q == S_IDLE) && !rst;
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q == S_SORT);
   assign out_data    = data_q;
   assign phase_count = cnt_q;

endmodule

// File: doc/brick_sort_iter.md
BRICK_SORT_ITER -- requirements
Module: brick_sort_iter

Interface
REQ-001 SHALL have parameter LOG_INPUT_NUM, default 4; element count N = 2**LOG_INPUT_NUM (N >= 4).
REQ-002 SHALL have parameter DATA_WIDTH, default 32; width of one element.
REQ-003 SHALL have parameter SIGNED, default 0; 1 = two's-complement compare, 0 = unsigned.
REQ-004 SHALL have parameter ASCENDING, default 1; 1 = lower index holds the smaller value, 0 = the larger.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, N*DATA_WIDTH); element i is in_data[(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, N*DATA_WIDTH), using the same element packing as in_data.
REQ-009 SHALL have port busy, output, 1, high while sorting.
REQ-010 SHALL have port phase_count, output, LOG_INPUT_NUM+1, the number of phases executed for the current or last vector.

Function
REQ-011 SHALL implement states IDLE, SORT and DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE; an accept (in_valid & in_ready at an edge) loads in_data into the working register, clears phase_count and enters SORT.
REQ-013 SHALL apply exactly one phase per cycle in SORT, and each phase SHALL increment phase_count.
REQ-014 SHALL alternate phases: even phases (phase_count even before the edge) compare-exchange pairs (0,1),(2,3)...(N-2,N-1); odd phases compare-exchange pairs (1,2)...(N-3,N-2), passing elements 0 and N-1 through unchanged.
REQ-015 SHALL swap a pair only when it is strictly out of order; equal elements SHALL NOT swap.
REQ-016 SHALL enter DONE at the edge that completes phase N-1, so out_valid rises exactly N cycles after the accept edge.
REQ-017 SHALL drive out_valid = 1 only in DONE, with out_data equal to the working register and held stable until out_valid & out_ready.
REQ-018 SHALL return to IDLE on the out_valid & out_ready edge, with in_ready rising the next cycle; no new vector is accepted in the same edge.
REQ-019 SHALL ignore in_valid in SORT and DONE, and ignore out_ready outside DONE.
REQ-020 SHALL drive busy = 1 exactly in SORT.
REQ-021 SHALL hold phase_count after DONE until the next accept.

Reset
REQ-022 SHALL, on rst assertion, immediately force IDLE, clear the working register, set out_data = 0, out_valid = 0, busy = 0 and phase_count = 0, and set in_ready = 1 after rst deasserts.
REQ-023 SHALL discard any in-flight vector on reset during SORT or DONE, without producing a partial output.

Configuration
REQ-024 SHALL support macro BRICK_SORT_EARLY_EXIT_EN; when defined, the block SHALL track per-phase swaps and SHALL enter DONE after any phase where both that phase and the immediately preceding phase performed zero swaps (minimum 2 phases), otherwise it SHALL end at N phases.
REQ-025 SHALL, when BRICK_SORT_EARLY_EXIT_EN is undefined, always execute exactly N phases and contain no swap-tracking logic.

Verification (LOG_INPUT_NUM=2, DATA_WIDTH=8 unless stated)
REQ-026 Elements [3,1,2,0] accepted, ASCENDING=1, SIGNED=0 -> out_data elements [0,1,2,3], out_valid high 4 cycles after accept, phase_count=4.
REQ-027 SIGNED=1, elements [0xFF,0x05,0x80,0x00] -> [0x80,0xFF,0x00,0x05]; with SIGNED=0 -> [0x00,0x05,0x80,0xFF].
REQ-028 ASCENDING=0, elements [1,4,2,3] -> [4,3,2,1].
REQ-029 out_ready held 0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-030 rst pulsed 2 cycles after accept -> out_valid=0, busy=0, phase_count=0, in_ready=1 after release; a following vector [2,2,1,1] sorts to [1,1,2,2].
REQ-031 Already-sorted [0,1,2,3] -> phase_count=2 and out_valid 2 cycles after accept with BRICK_SORT_EARLY_EXIT_EN defined; phase_count=4 when undefined.
